// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// lat_cnt_w sizes the per-register countdown so it can hold the longest latency.
package mips_hazard_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_WB_LAT   = 2;
  localparam int DEF_LOAD_LAT = 1;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;

  function automatic int lat_cnt_w(input int wb_lat, input int load_lat);
    int max_lat;
    max_lat = (wb_lat > load_lat) ? wb_lat : load_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register countdown: cycles left until the pending result is readable.
// A new set only wins when it is longer than the decremented count (WAW keeps the longer wait).
module hazard_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic             ip_clk,
  input  logic             ip_rst,
  input  logic             ip_set_en,
  input  logic [CNT_W-1:0] ip_set_val,
  output logic             op_busy
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] dec_val;

  always_comb begin
    dec_val = (count_q == '0) ? '0 : count_q - CNT_W'(1);
    count_d = dec_val;
    if (ip_set_en && (ip_set_val > dec_val)) begin
      count_d = ip_set_val;
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign op_busy = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard, source-match stall logic,
// issue qualification and a saturating stall-cycle statistics counter.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_SRC  = 2,
  parameter int FWD_EN   = 0,
  parameter int WB_LAT   = DEF_WB_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int STAT_W   = 32,
  localparam int REG_W   = $clog2(NUM_REGS)
) (
  input  logic                            ip_clk,
  input  logic                            ip_rst,
  input  logic                            ip_issue_valid,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   ip_src_reg,
  input  logic [NUM_SRC-1:0]              ip_src_use,
  input  logic [REG_W-1:0]                ip_dest_reg,
  input  logic                            ip_RegWrite,
  input  logic                            ip_Lw,
  input  logic                            ip_hold,
  input  logic                            ip_flush,
  output logic                            op_stall,
  output logic [NUM_REGS-1:0]             op_busy_mask,
  output logic [STAT_W-1:0]               op_stall_cycles
);

  localparam int CNT_W = lat_cnt_w(WB_LAT, LOAD_LAT);

  logic [NUM_REGS-1:0] busy;
  logic                src_hit;
  logic                fire;
  logic [CNT_W-1:0]    lat;
  logic [STAT_W-1:0]   stall_cycles_q;
  logic [STAT_W-1:0]   stall_cycles_d;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ip_src_use[i] && (ip_src_reg[i] != '0) && busy[ip_src_reg[i]]) begin
        src_hit = 1'b1;
      end
    end
  end

  assign op_stall = ip_issue_valid & src_hit;
  assign fire     = ip_issue_valid & ~op_stall & ~ip_hold & ~ip_flush;

  // With forwarding only loads leave a gap; ALU results are bypassed with latency 0.
  always_comb begin
    if (FWD_EN != 0) begin
      lat = ip_Lw ? CNT_W'(LOAD_LAT) : '0;
    end else begin
      lat = CNT_W'(WB_LAT);
    end
  end

  assign busy[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      hazard_reg_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .ip_clk    (ip_clk),
        .ip_rst    (ip_rst),
        .ip_set_en (fire & ip_RegWrite & (ip_dest_reg == REG_W'(gi))),
        .ip_set_val(lat),
        .op_busy   (busy[gi])
      );
    end
  endgenerate

  assign op_busy_mask = busy;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (op_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STAT_W'(1);
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign op_stall_cycles = stall_cycles_q;

endmodule
